if_trace_buffer: RTL and testbench

- Downstream consumer of the IF-stage tracker.
- Captures each completed instruction-fetch trace record (a ryuki_datatypes::trace_output presented with the level-style if_data_ready flag) into a circular FIFO.
- Drains records to the trace export/merge logic over a valid/ready handshake.
- Counts records lost to overflow, so trace gaps are detectable off-chip.

---
 rtl/if_trace_buffer.sv | 109 ++++++++++
 tb/tb_if_trace_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_trace_buffer.sv
// IF-stage trace buffer: captures completed fetch trace records on the rising
// edge of the tracker's level flag, holds them in a circular FIFO with
// first-word fall-through output, and counts records lost to overflow.

package ryuki_datatypes;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instruction;
  } trace_output;
endpackage

module if_trace_buffer
  import ryuki_datatypes::*;
#(
  parameter int TRACE_BUFFER_SIZE = 128,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 if_data_ready,
  input  trace_output                          if_data_i,
  input  logic                                 flush,
  input  logic                                 trace_ready,
  output logic                                 trace_valid,
  output trace_output                          trace_data_o,
  output logic [$clog2(TRACE_BUFFER_SIZE):0]   occupancy,
  output logic                                 full,
  output logic                                 empty,
  output logic [CNT_WIDTH-1:0]                 overflow_count
);

  localparam int PTR_W = $clog2(TRACE_BUFFER_SIZE);
  localparam int OCC_W = PTR_W + 1;

  logic                 r_ready_q;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [OCC_W-1:0]     r_occ;
  logic [CNT_WIDTH-1:0] r_ovf;
  trace_output          r_mem [TRACE_BUFFER_SIZE];

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_drop;

  // A record completes on the 0->1 edge of the tracker flag; a held flag
  // produces one push only. A push into a full FIFO still fits when the
  // head leaves on the same edge.
  assign w_full   = (r_occ == OCC_W'(TRACE_BUFFER_SIZE));
  assign w_empty  = (r_occ == OCC_W'(0));
  assign w_push   = if_data_ready & ~r_ready_q;
  assign w_pop    = ~w_empty & trace_ready;
  assign w_accept = w_push & (~w_full | w_pop);
  assign w_drop   = w_push & w_full & ~w_pop;

  // Outputs decode registered state only; trace_ready never reaches them
  // combinationally.
  assign trace_valid    = ~w_empty;
  assign empty          = w_empty;
  assign full           = w_full;
  assign occupancy      = r_occ;
  assign overflow_count = r_ovf;
  assign trace_data_o   = r_mem[r_rd_ptr];

  // Pointer, occupancy, edge-detect and overflow-counter state; flush wins
  // over any same-cycle push or pop but leaves the overflow counter alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready_q <= 1'b1;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_ovf     <= '0;
    end else begin
      r_ready_q <= if_data_ready;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_accept, w_pop})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
        if (w_drop && (r_ovf != {CNT_WIDTH{1'b1}})) begin
          r_ovf <= r_ovf + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Record storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TRACE_BUFFER_SIZE; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!flush && w_accept) begin
      r_mem[r_wr_ptr] <= if_data_i;
    end
  end

endmodule

// File: tb/tb_if_trace_buffer.sv
// Self-checking bench for if_trace_buffer: a queue-based FIFO model predicts
// contents, occupancy and overflow count from flag edges and handshakes.
module tb_if_trace_buffer;
  import ryuki_datatypes::*;

  localparam int SIZE = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_data_ready = 1'b0;
  trace_output if_data_i = '0;
  logic        flush = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  trace_output trace_data_o;
  logic [7:0]  occupancy;
  logic        full;
  logic        empty;
  logic [31:0] overflow_count;

  // Small instance for counter saturation.
  logic        rst2 = 1'b0;
  logic        rdy2 = 1'b0;
  trace_output din2 = '0;
  logic        valid2;
  trace_output dout2;
  logic [1:0]  occ2;
  logic        full2;
  logic        empty2;
  logic [2:0]  ovf2;

  int total = 0;
  int bad = 0;

  trace_output q[$];
  logic        m_prev = 1'b1;
  longint      m_ovf = 0;

  always #5 clk = ~clk;

  if_trace_buffer #(.TRACE_BUFFER_SIZE(SIZE), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .if_data_ready(if_data_ready), .if_data_i(if_data_i),
    .flush(flush), .trace_ready(trace_ready), .trace_valid(trace_valid),
    .trace_data_o(trace_data_o), .occupancy(occupancy), .full(full),
    .empty(empty), .overflow_count(overflow_count)
  );

  if_trace_buffer #(.TRACE_BUFFER_SIZE(2), .CNT_WIDTH(3)) dut2 (
    .clk(clk), .rst(rst2), .if_data_ready(rdy2), .if_data_i(din2),
    .flush(1'b0), .trace_ready(1'b0), .trace_valid(valid2),
    .trace_data_o(dout2), .occupancy(occ2), .full(full2),
    .empty(empty2), .overflow_count(ovf2)
  );

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
  task automatic cyc(input logic lvl, input logic [31:0] a, input logic [31:0] ins,
                     input logic tr, input logic fl);
    logic push;
    logic pop;
    if_data_ready = lvl;
    if_data_i.addr = a;
    if_data_i.instruction = ins;
    trace_ready = tr;
    flush = fl;
    @(posedge clk);
    push = lvl & ~m_prev;
    pop = (q.size() > 0) & tr;
    m_prev = lvl;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        if (q.size() < SIZE) begin
          trace_output rec;
          rec.addr = a;
          rec.instruction = ins;
          q.push_back(rec);
        end else if (m_ovf < 64'hFFFF_FFFF) begin
          m_ovf = m_ovf + 1;
        end
      end
    end
    #1;
    flush = 1'b0;
  endtask

  task automatic push_rec(input logic [31:0] a, input logic [31:0] ins, input logic tr);
    cyc(1'b0, a, ins, tr, 1'b0);
    cyc(1'b1, a, ins, tr, 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b exp=0", full); end
    total++; if (trace_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", trace_valid); end
    total++; if (occupancy !== 8'd0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (overflow_count !== 32'd0) begin bad++; $display("FAIL reset_ovf got=%0d exp=0", overflow_count); end
    total++; if (trace_data_o !== 64'd0) begin bad++; $display("FAIL reset_data got=%h exp=0", trace_data_o); end
    @(negedge clk);
    rst = 1'b1;
    m_prev = 1'b1;
  endtask

  task automatic test_first_push;
    push_rec(32'h0000_0080, 32'h0000_0013, 1'b0);
    total++; if (trace_valid !== 1'b1) begin bad++; $display("FAIL first_valid got=%0b exp=1", trace_valid); end
    total++; if (trace_data_o.addr !== 32'h0000_0080) begin bad++; $display("FAIL first_addr got=%h exp=00000080", trace_data_o.addr); end
    total++; if (trace_data_o.instruction !== 32'h0000_0013) begin bad++; $display("FAIL first_instr got=%h exp=00000013", trace_data_o.instruction); end
    total++; if (occupancy !== 8'd1) begin bad++; $display("FAIL first_occ got=%0d exp=1", occupancy); end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      total++; if (occupancy !== 8'd1) begin bad++; $display("FAIL held_flag_occ cyc=%0d got=%0d exp=1", i, occupancy); end
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL first_drain_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_fill_overflow;
    logic [31:0] last_addr;
    for (int i = 0; i < SIZE; i++) push_rec(32'h1000 + 32'(i * 4), $urandom, 1'b0);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b exp=1", full); end
    total++; if (occupancy !== 8'd128) begin bad++; $display("FAIL fill_occ got=%0d exp=128", occupancy); end
    for (int i = 0; i < 3; i++) push_rec(32'hBAD0_0000 + 32'(i), $urandom, 1'b0);
    total++; if (overflow_count !== 32'd3) begin bad++; $display("FAIL ovf_three got=%0d exp=3", overflow_count); end
    total++; if (trace_data_o !== q[0]) begin bad++; $display("FAIL ovf_head got=%h exp=%h", trace_data_o, q[0]); end
    // push together with pop while full
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'hDEAD_0000, 32'h1234_5678, 1'b1, 1'b0);
    total++; if (occupancy !== 8'd128) begin bad++; $display("FAIL fullpp_occ got=%0d exp=128", occupancy); end
    total++; if (overflow_count !== 32'(m_ovf)) begin bad++; $display("FAIL fullpp_ovf got=%0d exp=%0d", overflow_count, m_ovf); end
    last_addr = 32'd0;
    for (int i = 0; i < SIZE + 4 && q.size() > 0; i++) begin
      total++; if (trace_data_o !== q[0]) begin bad++; $display("FAIL drain_data i=%0d got=%h exp=%h", i, trace_data_o, q[0]); end
      last_addr = trace_data_o.addr;
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    end
    total++; if (last_addr !== 32'hDEAD_0000) begin bad++; $display("FAIL drain_last got=%h exp=dead0000", last_addr); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 300; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0);
      if (trace_valid !== 1'b1 || occupancy > 8'd1 || trace_data_o !== q[0]) begin
        bad++; $display("FAIL wrap_push i=%0d got=%h occ=%0d exp=%h", i, trace_data_o, occupancy, q[0]);
      end
      total++;
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_empty i=%0d got=%0b exp=1", i, empty); end
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) push_rec($urandom, $urandom, 1'b0);
    cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'h5555_0000, 32'd1, 1'b0, 1'b1);
    total++; if (occupancy !== 8'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%0b exp=1", empty); end
    total++; if (overflow_count !== 32'(m_ovf)) begin bad++; $display("FAIL flush_ovf got=%0d exp=%0d", overflow_count, m_ovf); end
    push_rec(32'h6666_0000, 32'd2, 1'b0);
    total++; if (occupancy !== 8'd1) begin bad++; $display("FAIL flush_next_occ got=%0d exp=1", occupancy); end
    total++; if (trace_data_o.addr !== 32'h6666_0000) begin bad++; $display("FAIL flush_next_addr got=%h exp=66660000", trace_data_o.addr); end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 10; i++) push_rec($urandom, $urandom, 1'b0);
    total++; if (occupancy !== 8'd10) begin bad++; $display("FAIL mid_pre_occ got=%0d exp=10", occupancy); end
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_prev = 1'b1;
    total++; if (occupancy !== 8'd0) begin bad++; $display("FAIL mid_async_occ got=%0d exp=0", occupancy); end
    total++; if (overflow_count !== 32'd0) begin bad++; $display("FAIL mid_async_ovf got=%0d exp=0", overflow_count); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0);
      total++; if (occupancy !== 8'd0) begin bad++; $display("FAIL mid_held_occ i=%0d got=%0d exp=0", i, occupancy); end
    end
    push_rec(32'h7777_0000, 32'd3, 1'b0);
    total++; if (occupancy !== 8'd1) begin bad++; $display("FAIL mid_fresh_occ got=%0d exp=1", occupancy); end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation;
    int exp;
    @(negedge clk);
    rst2 = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      rdy2 = 1'b0; din2.addr = $urandom;
      @(posedge clk); #1;
      rdy2 = 1'b1;
      @(posedge clk); #1;
      exp = (n > 2) ? n - 2 : 0;
      if (exp > 7) exp = 7;
      total++; if (ovf2 !== 3'(exp)) begin bad++; $display("FAIL sat_ovf n=%0d got=%0d exp=%0d", n, ovf2, exp); end
    end
    total++; if (full2 !== 1'b1) begin bad++; $display("FAIL sat_full got=%0b exp=1", full2); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 1500; i++) begin
      logic tr;
      tr = (i < 700) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      cyc(1'($urandom), $urandom, $urandom, tr, ($urandom_range(0, 99) == 0));
      total++; if (occupancy !== 8'(q.size())) begin bad++; $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, occupancy, q.size()); end
      total++; if (overflow_count !== 32'(m_ovf)) begin bad++; $display("FAIL rnd_ovf i=%0d got=%0d exp=%0d", i, overflow_count, m_ovf); end
      total++; if (full !== (q.size() == SIZE)) begin bad++; $display("FAIL rnd_full i=%0d got=%0b", i, full); end
      if (q.size() > 0) begin
        total++; if (trace_data_o !== q[0]) begin bad++; $display("FAIL rnd_data i=%0d got=%h exp=%h", i, trace_data_o, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_push();
    test_fill_overflow();
    test_wrap();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
